// File: rtl/seq_scan_pkg.sv
// ============================================================================
// Module   : seq_scan_pkg
// Brief    : Shared state encoding and width helpers for the serial-pattern
//            scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_scan_pkg;

   localparam int unsigned c_state_w = 2;

   typedef enum logic [c_state_w-1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Width able to hold a pattern length of 0..pat_w inclusive.
   function automatic int unsigned len_w(input int unsigned pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_scan_if.sv
// ============================================================================
// Module   : seq_scan_if
// Brief    : Serial bit stream valid/ready handshake between a bit source
//            (master) and the scan controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_scan_if;

   logic bit_valid;
   logic bit_in;
   logic bit_ready;

   modport master (
      output bit_valid,
      output bit_in,
      input  bit_ready
   );

   modport slave (
      input  bit_valid,
      input  bit_in,
      output bit_ready
   );

endinterface

`default_nettype wire

// File: rtl/seq_scan_ctrl_window.sv
// ============================================================================
// Module   : seq_window
// Brief    : Bit history shift register, fill count and length-masked
//            pattern compare; hit reflects the window after the current shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_window
   import seq_scan_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [LEN_W-1:0] len,
   input  logic [PAT_W-1:0] pattern,
   input  logic             clr_fill,
   output logic             hit
);

   logic [PAT_W-1:0] r_window;
   logic [PAT_W-1:0] w_window_nxt;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W-1:0] r_fill;
   logic [LEN_W-1:0] w_fill_nxt;

   assign w_window_nxt = {r_window[PAT_W-2:0], bit_in};
   assign w_fill_nxt   = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < int'(len));
      end
   end

   // Compare against the post-shift window so the result can be registered
   // on the same edge that accepts the bit.
   assign hit = shift_en
              && (len != '0)
              && (((w_window_nxt ^ pattern) & w_mask) == '0)
              && (w_fill_nxt >= len);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_window <= '0;
         r_fill   <= '0;
      end else if (clr) begin
         r_window <= '0;
         r_fill   <= '0;
      end else if (shift_en) begin
         r_window <= w_window_nxt;
         r_fill   <= clr_fill ? '0 : w_fill_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
// ============================================================================
// Module   : seq_scan_ctrl
// Brief    : Programmable serial-pattern scan controller: counts pattern
//            matches over a frame of handshaked bits and pulses done at the end.
//            Define SEQ_SCAN_FIRST_IDX_EN to add first-match index capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PAT_W-1:0]             cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   input  logic                         cfg_overlap,
   input  logic [CNT_W-1:0]             cfg_frame_len,
   input  logic                         start,
   input  logic                         abort,
   seq_scan_if.slave                    bit_if,
   output logic                         busy,
   output logic                         match_pulse,
   output logic [CNT_W-1:0]             match_count,
   output logic                         done
`ifdef SEQ_SCAN_FIRST_IDX_EN
   ,
   output logic                         first_vld,
   output logic [CNT_W-1:0]             first_idx
`endif
);

   localparam int unsigned        c_len_w   = len_w(PAT_W);
   localparam logic [CNT_W-1:0]   c_cnt_max = '1;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [PAT_W-1:0]   r_pattern;
   logic [c_len_w-1:0] r_len;
   logic               r_overlap;
   logic [CNT_W-1:0]   r_frame_len;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_match_pulse;
   logic [CNT_W-1:0]   r_match_count;

   logic               w_bit_ready;
   logic               w_busy;
   logic               w_done;
   logic               w_start;
   logic               w_accept;
   logic               w_last;
   logic               w_hit;
   logic [CNT_W-1:0]   w_bit_cnt_inc;

   assign w_start       = (r_state == S_IDLE) && start;
   assign w_accept      = bit_if.bit_valid && w_bit_ready;
   assign w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);
   assign w_last        = w_accept && (w_bit_cnt_inc == r_frame_len);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (cfg_frame_len == '0) ? S_DONE : S_SCAN;
            end
         end
         S_SCAN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_bit_ready = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_SCAN: begin
            w_bit_ready = ~abort;
            w_busy      = 1'b1;
         end
         S_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   seq_window #(
      .PAT_W (PAT_W),
      .LEN_W (c_len_w)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_start),
      .shift_en (w_accept),
      .bit_in   (bit_if.bit_in),
      .len      (r_len),
      .pattern  (r_pattern),
      .clr_fill (w_hit && !r_overlap),
      .hit      (w_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pattern     <= '0;
         r_len         <= '0;
         r_overlap     <= 1'b0;
         r_frame_len   <= '0;
         r_bit_cnt     <= '0;
         r_match_pulse <= 1'b0;
         r_match_count <= '0;
      end else if (w_start) begin
         r_pattern     <= cfg_pattern;
         r_len         <= (cfg_len > c_len_w'(PAT_W)) ? c_len_w'(PAT_W) : cfg_len;
         r_overlap     <= cfg_overlap;
         r_frame_len   <= cfg_frame_len;
         r_bit_cnt     <= '0;
         r_match_pulse <= 1'b0;
         r_match_count <= '0;
      end else begin
         r_match_pulse <= w_hit;
         // Pulse keeps firing once the counter pins at its maximum.
         if (w_hit && (r_match_count != c_cnt_max)) begin
            r_match_count <= r_match_count + CNT_W'(1);
         end
         if (w_accept) begin
            r_bit_cnt <= w_bit_cnt_inc;
         end
      end
   end

   assign bit_if.bit_ready = w_bit_ready;
   assign busy             = w_busy;
   assign done             = w_done;
   assign match_pulse      = r_match_pulse;
   assign match_count      = r_match_count;

`ifdef SEQ_SCAN_FIRST_IDX_EN
   logic             r_first_vld;
   logic [CNT_W-1:0] r_first_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_first_vld <= 1'b0;
         r_first_idx <= '0;
      end else if (w_start) begin
         r_first_vld <= 1'b0;
         r_first_idx <= '0;
      end else if (w_hit && !r_first_vld) begin
         r_first_vld <= 1'b1;
         r_first_idx <= r_bit_cnt;
      end
   end

   assign first_vld = r_first_vld;
   assign first_idx = r_first_idx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
// ============================================================================
// Module   : tb_seq_scan_ctrl
// Brief    : Self-checking bench for seq_scan_ctrl against a match-position
//            reference model computed from the bit stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_scan_ctrl;

   localparam int PAT_W = 8;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [PAT_W-1:0] cfg_pattern;
   logic [3:0]       cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_frame_len;
   logic             start, abort;
   logic             busy, match_pulse, done;
   logic [CNT_W-1:0] match_count;
   logic             first_vld;
   logic [CNT_W-1:0] first_idx;

   logic [3:0]       s_cfg_pattern;
   logic [2:0]       s_cfg_len;
   logic             s_cfg_overlap;
   logic [1:0]       s_cfg_frame_len;
   logic             s_start, s_abort;
   logic             s_busy, s_match_pulse, s_done;
   logic [1:0]       s_match_count;
   logic             s_first_vld;
   logic [1:0]       s_first_idx;

   seq_scan_if bus ();
   seq_scan_if bus2 ();

   seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_pattern   (cfg_pattern),
      .cfg_len       (cfg_len),
      .cfg_overlap   (cfg_overlap),
      .cfg_frame_len (cfg_frame_len),
      .start         (start),
      .abort         (abort),
      .bit_if        (bus),
      .busy          (busy),
      .match_pulse   (match_pulse),
      .match_count   (match_count),
      .done          (done)
`ifdef SEQ_SCAN_FIRST_IDX_EN
      ,
      .first_vld     (first_vld),
      .first_idx     (first_idx)
`endif
   );

   seq_scan_ctrl #(.PAT_W(4), .CNT_W(2)) dut_sat (
      .clk           (clk),
      .rst           (rst),
      .cfg_pattern   (s_cfg_pattern),
      .cfg_len       (s_cfg_len),
      .cfg_overlap   (s_cfg_overlap),
      .cfg_frame_len (s_cfg_frame_len),
      .start         (s_start),
      .abort         (s_abort),
      .bit_if        (bus2),
      .busy          (s_busy),
      .match_pulse   (s_match_pulse),
      .match_count   (s_match_count),
      .done          (s_done)
`ifdef SEQ_SCAN_FIRST_IDX_EN
      ,
      .first_vld     (s_first_vld),
      .first_idx     (s_first_idx)
`endif
   );

`ifndef SEQ_SCAN_FIRST_IDX_EN
   assign first_vld   = 1'b0;
   assign first_idx   = '0;
   assign s_first_vld = 1'b0;
   assign s_first_idx = '0;
`endif

   int checks   = 0;
   int failures = 0;

   bit m_bits [256];
   bit m_hit  [256];

   logic [15:0] stream = 16'b0101101010110101;

   // Reference: bit i completes a match if the last len bits since the most
   // recent restart point equal the pattern (pattern bit 0 = newest bit).
   task automatic compute_model(input logic [7:0] pat, input int len, input bit ov, input int frame);
      int lm, base;
      bit ok;
      lm   = (len > PAT_W) ? PAT_W : len;
      base = 0;
      for (int i = 0; i < frame; i++) begin
         m_hit[i] = 1'b0;
         if (lm > 0 && (i - base + 1) >= lm) begin
            ok = 1'b1;
            for (int j = 0; j < lm; j++) if (m_bits[i-j] != pat[j]) ok = 1'b0;
            if (ok) begin
               m_hit[i] = 1'b1;
               if (!ov) base = i + 1;
            end
         end
      end
   endtask

   task automatic load_stream();
      for (int i = 0; i < 16; i++) m_bits[i] = stream[15-i];
   endtask

   // vmode: 0 = valid always, 1 = toggling, 2 = random
   task automatic run_scan(input logic [7:0] pat, input int len, input bit ov, input int frame,
                           input int vmode, input int abort_at, input bit disturb);
      int acc, nmatch, cyc, prev_idx, first;
      bit prev_acc, fin, aborted, tog, v;
      logic exp_pulse, exp_done;
      logic [CNT_W-1:0] exp_cnt;
      compute_model(pat, len, ov, frame);
      first = -1;
      for (int i = frame - 1; i >= 0; i--) if (m_hit[i]) first = i;
      cfg_pattern   = pat;
      cfg_len       = len[3:0];
      cfg_overlap   = ov;
      cfg_frame_len = frame[7:0];
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      acc = 0; nmatch = 0; cyc = 0; prev_idx = 0;
      prev_acc = 0; fin = 0; aborted = 0; tog = 1;
      while (!fin && cyc < 1000) begin
         start     = 1'b0;
         exp_pulse = prev_acc && m_hit[prev_idx];
         if (exp_pulse) nmatch++;
         exp_cnt  = (nmatch > 255) ? 8'd255 : nmatch[7:0];
         exp_done = (frame == 0 && cyc == 0) || (prev_acc && prev_idx == frame - 1);
         checks++;
         if (match_pulse !== exp_pulse) begin
            failures++;
            $display("FAIL match_pulse cyc=%0d got=%b exp=%b", cyc, match_pulse, exp_pulse);
         end
         checks++;
         if (match_count !== exp_cnt) begin
            failures++;
            $display("FAIL match_count cyc=%0d got=%0d exp=%0d", cyc, match_count, exp_cnt);
         end
         checks++;
         if (done !== exp_done || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_busy cyc=%0d got=%b/%b exp=%b/1", cyc, done, busy, exp_done);
         end
         if (exp_done) begin
            bus.bit_valid = 1'b1;
            #1;
            checks++;
            if (bus.bit_ready !== 1'b0) begin
               failures++;
               $display("FAIL ready_in_done got=%b exp=0", bus.bit_ready);
            end
            fin = 1;
         end else if (abort_at >= 0 && acc == abort_at) begin
            abort = 1'b1;
            bus.bit_valid = 1'b1;
            bus.bit_in = m_bits[acc];
            #1;
            checks++;
            if (bus.bit_ready !== 1'b0) begin
               failures++;
               $display("FAIL ready_on_abort got=%b exp=0", bus.bit_ready);
            end
            @(posedge clk); #1;
            abort = 1'b0;
            aborted = 1;
            fin = 1;
         end else begin
            case (vmode)
               0:       v = 1'b1;
               1:       begin v = tog; tog = ~tog; end
               default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.bit_valid = v;
            bus.bit_in    = m_bits[acc];
            if (disturb) begin
               start         = $urandom_range(0, 1);
               cfg_pattern   = 8'($urandom);
               cfg_len       = 4'($urandom);
               cfg_overlap   = $urandom_range(0, 1);
               cfg_frame_len = 8'($urandom);
            end
            #1;
            checks++;
            if (bus.bit_ready !== 1'b1) begin
               failures++;
               $display("FAIL ready_in_scan acc=%0d got=%b exp=1", acc, bus.bit_ready);
            end
            prev_acc = v;
            prev_idx = acc;
            if (v) acc++;
            @(posedge clk); #1;
         end
         cyc++;
      end
      start = 1'b0;
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL scan_timeout got=running exp=done");
      end
      if (!aborted) begin
         @(posedge clk); #1;
      end
      exp_cnt = (nmatch > 255) ? 8'd255 : nmatch[7:0];
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || match_pulse !== 1'b0 || bus.bit_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_after busy/done/pulse/ready got=%b%b%b%b exp=0000",
                  busy, done, match_pulse, bus.bit_ready);
      end
      checks++;
      if (match_count !== exp_cnt) begin
         failures++;
         $display("FAIL count_hold got=%0d exp=%0d", match_count, exp_cnt);
      end
`ifdef SEQ_SCAN_FIRST_IDX_EN
      begin
         int lim;
         lim = aborted ? prev_idx + (prev_acc ? 1 : 0) : frame;
         if (first >= lim) first = -1;
         checks++;
         if (first_vld !== (first >= 0) || (first >= 0 && first_idx !== first[7:0])) begin
            failures++;
            $display("FAIL first_idx got=%b/%0d exp=%b/%0d", first_vld, first_idx, first >= 0, first);
         end
      end
`endif
      bus.bit_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || match_pulse !== 0 || match_count !== 0 || bus.bit_ready !== 0
          || first_vld !== 0) begin
         failures++;
         $display("FAIL reset_state got=%b%b%b%0d%b exp=00000", busy, done, match_pulse, match_count, bus.bit_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 0 || s_busy !== 0) begin
         failures++;
         $display("FAIL idle_after_reset got=%b/%b exp=0/0", busy, s_busy);
      end
   endtask

   task automatic test_overlap();
      load_stream();
      run_scan(8'b101, 3, 1'b1, 16, 0, -1, 1'b0);
   endtask

   task automatic test_nonoverlap();
      load_stream();
      run_scan(8'b101, 3, 1'b0, 16, 0, -1, 1'b0);
   endtask

   task automatic test_toggle_valid();
      load_stream();
      run_scan(8'b101, 3, 1'b1, 16, 1, -1, 1'b0);
   endtask

   task automatic test_frame_zero();
      run_scan(8'b101, 3, 1'b1, 0, 0, -1, 1'b0);
   endtask

   task automatic test_abort_rearm();
      load_stream();
      run_scan(8'b101, 3, 1'b1, 16, 0, 5, 1'b0);
      run_scan(8'b101, 3, 1'b1, 16, 0, -1, 1'b0);
   endtask

   task automatic test_saturation();
      int n;
      logic [1:0] exp_cnt;
      s_cfg_pattern = 4'b0001; s_cfg_len = 3'd1; s_cfg_overlap = 1'b1; s_cfg_frame_len = 2'd3;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      n = 0;
      bus2.bit_in = 1'b1;
      bus2.bit_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n++;
         exp_cnt = (n > 3) ? 2'd3 : n[1:0];
         checks++;
         if (s_match_pulse !== 1'b1 || s_match_count !== exp_cnt) begin
            failures++;
            $display("FAIL sat_count bit=%0d got=%b/%0d exp=1/%0d", i, s_match_pulse, s_match_count, exp_cnt);
         end
      end
      checks++;
      if (s_done !== 1'b1) begin
         failures++;
         $display("FAIL sat_done got=%b exp=1", s_done);
      end
      bus2.bit_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int len, frame, ab;
      logic [7:0] pat;
      for (int k = 0; k < 10; k++) begin
         pat   = 8'($urandom);
         len   = $urandom_range(0, 15);
         frame = $urandom_range(1, 40);
         if (k < 5) begin
            len = $urandom_range(1, 3);
            pat = pat & 8'h07;
         end
         for (int i = 0; i < frame; i++) m_bits[i] = $urandom_range(0, 1);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, frame - 1) : -1;
         run_scan(pat, len, $urandom_range(0, 1), frame, 2, ab, 1'b1);
      end
   endtask

   task automatic test_reset_mid_scan();
      load_stream();
      cfg_pattern = 8'b101; cfg_len = 4'd3; cfg_overlap = 1'b1; cfg_frame_len = 8'd16;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.bit_valid = 1'b1;
         bus.bit_in = m_bits[i];
         @(posedge clk); #1;
      end
      checks++;
      if (match_count !== 8'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset got=%0d/%b exp=1/1", match_count, busy);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || match_pulse !== 0 || match_count !== 0 || bus.bit_ready !== 0
          || first_vld !== 0) begin
         failures++;
         $display("FAIL async_reset got=%b%b%b%0d%b exp=00000", busy, done, match_pulse, match_count, bus.bit_ready);
      end
      #2 rst = 1'b0;
      bus.bit_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 0 || done !== 0) begin
         failures++;
         $display("FAIL post_reset got=%b/%b exp=0/0", busy, done);
      end
   endtask

   initial begin
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_frame_len = '0;
      start = 1'b0; abort = 1'b0;
      bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      s_cfg_pattern = '0; s_cfg_len = '0; s_cfg_overlap = 1'b0; s_cfg_frame_len = '0;
      s_start = 1'b0; s_abort = 1'b0;
      bus2.bit_valid = 1'b0; bus2.bit_in = 1'b0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_toggle_valid();
      test_frame_zero();
      test_abort_rearm();
      test_saturation();
      test_random();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
